axi_lite_rr_arbiter: RTL and testbench

AXI_LITE_RR_ARBITER -- requirements
Module: axi_lite_rr_arbiter

---
 rtl/axi_lite_rr_arbiter.sv | 114 +++++++++++
 tb/tb_axi_lite_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin arbiter that grants AXI-lite AR/AW valids from several crossbar masters.
// Defining AXI_LITE_RR_ARBITER_STATS_EN adds clr_i and saturating per-requester grant counters.
module axi_lite_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16,
  localparam int SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic               out_req_o,
  output logic [SEL_W-1:0]   out_sel_o,
  input  logic               out_ack_i
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
  ,
  input  logic                              clr_i,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_o
`endif
);

  // state | meaning
  // IDLE  | no grant offered; arbitrate req_i starting at ptr_q
  // OFFER | grant sel_q held on out_req_o/out_sel_o until out_ack_i
  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REQ - 1);
  localparam logic [SEL_W:0]   NUM_REQ_W = (SEL_W + 1)'(NUM_REQ);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pick;
  logic             pick_vld;
  logic [SEL_W:0]   cand;

  // Descending scan so the smallest offset from ptr_q wins; cand is wrapped below NUM_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (SEL_W + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req_i[cand[SEL_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d   = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (out_ack_i) begin
          ptr_d   = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Decoded straight from the state flop so reset drops the offer without waiting for a clock.
  assign out_req_o = (state_q == OFFER);
  assign out_sel_o = sel_q;

`ifdef AXI_LITE_RR_ARBITER_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if ((state_q == OFFER) && out_ack_i && (cnt_q[sel_q] != CNT_MAX)) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + CNT_WIDTH'(1);
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Randomized and directed bench for axi_lite_rr_arbiter (NUM_REQ = 4, 3 and 1 instances).
// Counter checks are active when AXI_LITE_RR_ARBITER_STATS_EN is defined.
module tb_axi_lite_rr_arbiter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_ni;
  logic [3:0] req4;
  logic       ack4, out_req4;
  logic [1:0] sel4;
  logic [2:0] req3;
  logic       ack3, out_req3;
  logic [1:0] sel3;
  logic [0:0] req1;
  logic       ack1, out_req1;
  logic [0:0] sel1;
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
  logic             clr4, clr3, clr1;
  logic [3:0][1:0]  cnt4;
  logic [2:0][15:0] cnt3;
  logic [0:0][15:0] cnt1;
`endif

  axi_lite_rr_arbiter #(.NUM_REQ(4), .CNT_WIDTH(2)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req4), .out_req_o(out_req4),
    .out_sel_o(sel4), .out_ack_i(ack4)
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    , .clr_i(clr4), .grant_cnt_o(cnt4)
`endif
  );

  axi_lite_rr_arbiter #(.NUM_REQ(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req3), .out_req_o(out_req3),
    .out_sel_o(sel3), .out_ack_i(ack3)
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    , .clr_i(clr3), .grant_cnt_o(cnt3)
`endif
  );

  axi_lite_rr_arbiter #(.NUM_REQ(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req1), .out_req_o(out_req1),
    .out_sel_o(sel1), .out_ack_i(ack1)
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    , .clr_i(clr1), .grant_cnt_o(cnt1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model for the 4-requester instance: pending offer index (-1 = none),
  // round-robin start index and saturating grant counts (max 3 for CNT_WIDTH=2).
  int m_ptr, m_offer, m_sel;
  int m_cnt[4];

  function automatic int rr_pick(input int ptr, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_offer = -1; m_sel = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic a, input logic c);
    int p;
    if (c) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (m_offer >= 0 && a && m_cnt[m_offer] < 3) begin
      m_cnt[m_offer]++;
    end
    if (m_offer < 0) begin
      p = rr_pick(m_ptr, r);
      if (p >= 0) begin
        m_offer = p;
        m_sel   = p;
      end
    end else if (a) begin
      m_ptr   = (m_offer + 1) % 4;
      m_offer = -1;
    end
  endtask

  task automatic compare4();
    check("out_req4", {31'd0, out_req4}, {31'd0, m_offer >= 0});
    check("out_sel4", {30'd0, sel4}, m_sel);
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    for (int i = 0; i < 4; i++) check("grant_cnt4", {30'd0, cnt4[i]}, m_cnt[i]);
`endif
  endtask

  // Apply inputs at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step4(input logic [3:0] r, input logic a, input logic c);
    req4 = r;
    ack4 = a;
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    clr4 = c;
`endif
    @(posedge clk_i);
    model_edge(r, a, c);
    @(negedge clk_i);
    compare4();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  int exp_req3[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int exp_sel3[8] = '{2, 2, 0, 0, 1, 1, 2, 2};

  initial begin
    rst_ni = 1'b0;
    req4 = '0; ack4 = 1'b0; req3 = '0; ack3 = 1'b0; req1 = '0; ack1 = 1'b0;
`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    clr4 = 1'b0; clr3 = 1'b0; clr1 = 1'b0;
`endif
    model_reset();
    #1;
    check("rst_out_req4", {31'd0, out_req4}, 0);
    check("rst_out_sel4", {30'd0, sel4}, 0);
    check("rst_out_req3", {31'd0, out_req3}, 0);
    repeat (2) @(negedge clk_i);
    compare4();

    // Release reset and arbitrate at once on the 3- and 1-requester instances.
    rst_ni = 1'b1;
    req3 = 3'b100; ack3 = 1'b0;
    req1 = 1'b1;   ack1 = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("n3_out_req", {31'd0, out_req3}, exp_req3[t]);
      check("n3_out_sel", {30'd0, sel3}, exp_sel3[t]);
      check("n1_out_req", {31'd0, out_req1}, (t % 2 == 0) ? 1 : 0);
      check("n1_out_sel", {31'd0, sel1}, 0);
      req3 = 3'b111; ack3 = 1'b1;
    end
    req3 = '0; ack3 = 1'b0; req1 = '0; ack1 = 1'b0;
    compare4();

    // All four requesting with immediate acks: offers 0,1,2,3,0 on every other cycle.
    for (int k = 1; k <= 10; k++) begin
      step4(4'b1111, 1'b1, 1'b0);
      check("rr_rate", {31'd0, out_req4}, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) check("rr_seq", {30'd0, sel4}, ((k - 1) / 2) % 4);
    end

    // Grant 2 leaves ptr at 3; a lone request 0 must wrap and leave ptr at 1.
    step4(4'b0100, 1'b0, 1'b0);
    check("grant2", {30'd0, sel4}, 2);
    step4(4'b0000, 1'b1, 1'b0);
    step4(4'b0001, 1'b0, 1'b0);
    check("wrap_sel0", {30'd0, sel4}, 0);
    step4(4'b0000, 1'b1, 1'b0);
    step4(4'b1111, 1'b0, 1'b0);
    check("ptr_after_wrap", {30'd0, sel4}, 1);

    // Offer to 1 held for five cycles without ack while requests wander.
    for (int k = 0; k < 5; k++) begin
      step4(4'($urandom), 1'b0, 1'b0);
      check("hold_req", {31'd0, out_req4}, 1);
      check("hold_sel", {30'd0, sel4}, 1);
    end
    step4(4'b0000, 1'b1, 1'b0);

`ifdef AXI_LITE_RR_ARBITER_STATS_EN
    step4(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step4(4'b0001, 1'b0, 1'b0);
      step4(4'b0000, 1'b1, 1'b0);
    end
    check("cnt_saturate", {30'd0, cnt4[0]}, 3);
    step4(4'b0001, 1'b0, 1'b0);
    step4(4'b0000, 1'b1, 1'b1);
    check("cnt_clr_wins", {30'd0, cnt4[0]}, 0);
`endif

    for (int k = 0; k < 400; k++) begin
      step4(4'($urandom), 1'($urandom), ($urandom_range(15) == 0));
    end

    // Reset in the middle of an offer.
    for (int k = 0; k < 20 && m_offer < 0; k++) step4(4'b0100, 1'b0, 1'b0);
    check("reach_offer", {31'd0, out_req4}, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_drop_req", {31'd0, out_req4}, 0);
    check("async_sel_zero", {30'd0, sel4}, 0);
    model_reset();
    @(negedge clk_i);
    compare4();
    rst_ni = 1'b1;
    step4(4'b1111, 1'b1, 1'b0);
    check("post_rst_grant", {30'd0, sel4}, 0);
    step4(4'b1111, 1'b1, 1'b0);
    step4(4'b1111, 1'b1, 1'b0);
    check("post_rst_next", {30'd0, sel4}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
